uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and data-width limits.
// Imported by uart_rx today and by the matching uart_tx later.
package uart_pkg;

  localparam int UART_MIN_DATA_WIDTH = 5;
  localparam int UART_MAX_DATA_WIDTH = 15;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter, so an idle-high line comes out of reset idle.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state always uses non-blocking assignments, so every flop
  // samples the pre-edge value of its neighbour and the chain cannot collapse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits,
// and a one-word output register with a valid/ready handshake and overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int CLK_DIV_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      rx_i,
  input  logic [CLK_DIV_WIDTH-1:0]  cfg_clk_div_i,
  input  logic [3:0]                cfg_data_width_i,
  input  logic [1:0]                cfg_parity_i,
  input  logic [1:0]                cfg_stop_width_i,
  output logic [MAX_DATA_WIDTH-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      parity_err_o,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      busy_o
);

  rx_state_e                 state, state_nxt;
  logic                      rx_s;
  logic [CLK_DIV_WIDTH-1:0]  cnt, div_q, div_eff;
  logic [3:0]                width_q, width_eff, bit_idx;
  parity_e                   parity_q;
  logic                      stop2_q, stop_idx;
  logic [MAX_DATA_WIDTH-1:0] sr;
  logic                      par_acc, perr, ferr;
  logic                      tick, par_en, last_bit, last_stop, frame_done;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk  (clk_i),
    .arst (arst_i),
    .d    (rx_i),
    .q    (rx_s)
  );

  // Out-of-range settings are clamped when the frame starts, never mid-frame.
  assign div_eff = (cfg_clk_div_i < CLK_DIV_WIDTH'(2)) ? CLK_DIV_WIDTH'(2) : cfg_clk_div_i;
  assign width_eff = (cfg_data_width_i < 4'(UART_MIN_DATA_WIDTH)) ? 4'(UART_MIN_DATA_WIDTH) :
                     (cfg_data_width_i > 4'(MAX_DATA_WIDTH))      ? 4'(MAX_DATA_WIDTH)      :
                                                                    cfg_data_width_i;

  assign tick      = (cnt <= CLK_DIV_WIDTH'(1));
  assign par_en    = (parity_q == PAR_ODD) || (parity_q == PAR_EVEN);
  assign last_bit  = (bit_idx == width_q - 4'd1);
  assign last_stop = (stop_idx == stop2_q);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_nxt = ST_START;
      ST_START:  if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && last_bit) state_nxt = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:   if (tick && last_stop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state != ST_IDLE);
    frame_done = (state == ST_STOP) && tick && last_stop;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt      <= '0;
      div_q    <= '0;
      width_q  <= '0;
      parity_q <= PAR_NONE;
      stop2_q  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      sr       <= '0;
      par_acc  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (!rx_s) begin
        div_q    <= div_eff;
        width_q  <= width_eff;
        parity_q <= parity_e'(cfg_parity_i);
        stop2_q  <= cfg_stop_width_i[1];
        cnt      <= div_eff >> 1;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        sr       <= '0;
        par_acc  <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end
    end else begin
      cnt <= tick ? div_q : cnt - 1'b1;
      if (tick) begin
        case (state)
          ST_DATA: begin
            sr      <= sr | (MAX_DATA_WIDTH'(rx_s) << bit_idx);
            par_acc <= par_acc ^ rx_s;
            bit_idx <= bit_idx + 4'd1;
          end
          ST_PARITY: perr <= (parity_q == PAR_ODD) ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
          ST_STOP: begin
            if (!rx_s) ferr <= 1'b1;
            stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A completed frame is dropped only when the held word has not been taken.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (frame_done && (!valid_o || ready_i)) begin
        data_o       <= sr;
        parity_err_o <= perr;
        frame_err_o  <= ferr | ~rx_s;
        valid_o      <= 1'b1;
      end else begin
        if (frame_done) overrun_o <= 1'b1;
        if (valid_o && ready_i) valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are built bit by bit on rx_i and every
// accepted word is captured by a monitor and compared with hand-computed values.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        arst_i;
  logic        rx_i;
  logic [15:0] cfg_clk_div_i;
  logic [3:0]  cfg_data_width_i;
  logic [1:0]  cfg_parity_i;
  logic [1:0]  cfg_stop_width_i;
  logic [7:0]  data_o;
  logic        valid_o, ready_i, parity_err_o, frame_err_o, overrun_o, busy_o;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  word_t got[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    valid_cycles = 0;
  int    overrun_cnt  = 0;
  bit    busy_seen    = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.MAX_DATA_WIDTH(8), .CLK_DIV_WIDTH(16)) dut (
    .clk_i            (clk),
    .arst_i           (arst_i),
    .rx_i             (rx_i),
    .cfg_clk_div_i    (cfg_clk_div_i),
    .cfg_data_width_i (cfg_data_width_i),
    .cfg_parity_i     (cfg_parity_i),
    .cfg_stop_width_i (cfg_stop_width_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .overrun_o        (overrun_o),
    .busy_o           (busy_o)
  );

  // Outputs are observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid_o) valid_cycles++;
    if (valid_o && ready_i) got.push_back({data_o, parity_err_o, frame_err_o});
    if (overrun_o) overrun_cnt++;
    if (busy_o) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives n line bits, LSB first, each held for div clocks.
  task automatic send_bits(input logic [31:0] bits, input int n, input int div);
    for (int i = 0; i < n; i++) begin
      rx_i = bits[i];
      cycles(div);
    end
    rx_i = 1'b1;
  endtask

  task automatic set_cfg(input int div, input int width, input logic [1:0] par,
                         input logic [1:0] stop);
    cfg_clk_div_i    = 16'(div);
    cfg_data_width_i = 4'(width);
    cfg_parity_i     = par;
    cfg_stop_width_i = stop;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] data,
                             input logic perr, input logic ferr);
    word_t w;
    check({tag, "_count"}, got.size(), 1);
    w = (got.size() > 0) ? got.pop_front() : '1;
    check({tag, "_data"}, w.data, data);
    check({tag, "_perr"}, w.perr, perr);
    check({tag, "_ferr"}, w.ferr, ferr);
    got.delete();
  endtask

  initial begin
    int vc0;
    arst_i  = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    set_cfg(4, 8, 2'b00, 2'd1);
    cycles(3);
    check("rst_data",  data_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);
    check("rst_busy",  busy_o, 1'b0);
    arst_i = 1'b0;
    cycles(5);

    // 0xA5, 8N1, div 4, consumer always ready
    vc0 = valid_cycles;
    send_bits({1'b1, 8'hA5, 1'b0}, 10, 4);
    cycles(20);
    expect_word("a5", 8'hA5, 1'b0, 1'b0);
    check("a5_valid_cycles", valid_cycles - vc0, 1);

    // one-clock low glitch at div 8 is rejected
    set_cfg(8, 8, 2'b00, 2'd1);
    busy_seen = 1'b0;
    vc0 = valid_cycles;
    send_bits(32'h0, 1, 1);
    cycles(30);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_now",  busy_o, 1'b0);
    check("glitch_no_valid",  valid_cycles - vc0, 0);
    check("glitch_no_word",   got.size(), 0);

    // width 4 clamps to 5; even parity, data 0x03 with parity bit 1 -> error
    set_cfg(4, 4, 2'b10, 2'd1);
    send_bits({1'b1, 1'b1, 5'b00011, 1'b0}, 8, 4);
    cycles(20);
    expect_word("par_even", 8'h03, 1'b1, 1'b0);

    // same line under odd parity carries correct parity
    set_cfg(4, 4, 2'b01, 2'd1);
    send_bits({1'b1, 1'b1, 5'b00011, 1'b0}, 8, 4);
    cycles(20);
    expect_word("par_odd", 8'h03, 1'b0, 1'b0);

    // two stop bits, second one low -> frame error
    set_cfg(4, 8, 2'b00, 2'd2);
    send_bits({1'b0, 1'b1, 8'h5A, 1'b0}, 11, 4);
    cycles(20);
    expect_word("stop2", 8'h5A, 1'b0, 1'b1);

    // overrun: consumer stalled for two frames
    set_cfg(4, 8, 2'b00, 2'd1);
    ready_i = 1'b0;
    overrun_cnt = 0;
    send_bits({1'b1, 8'h11, 1'b0}, 10, 4);
    cycles(8);
    send_bits({1'b1, 8'h22, 1'b0}, 10, 4);
    cycles(20);
    check("ovr_valid_held", valid_o, 1'b1);
    check("ovr_data_held",  data_o, 8'h11);
    check("ovr_pulses",     overrun_cnt, 1);
    ready_i = 1'b1;
    cycles(10);
    ready_i = 1'b1;
    expect_word("ovr_drain", 8'h11, 1'b0, 1'b0);
    check("ovr_valid_low", valid_o, 1'b0);

    // reset in the middle of the data bits of 0xFF
    send_bits({3'b111, 1'b0}, 4, 4);
    arst_i = 1'b1;
    cycles(2);
    arst_i = 1'b0;
    check("mid_rst_busy", busy_o, 1'b0);
    cycles(20);
    send_bits({1'b1, 8'h0F, 1'b0}, 10, 4);
    cycles(20);
    expect_word("after_rst", 8'h0F, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
